// File: rtl/fifo_wr_packer_if.sv
// Word-in / byte-out bundle between the upstream word source, fifo_wr_packer and the FIFO write port.
// The slave side is the packer; the master side is the word source plus the FIFO full flag.
interface fifo_wr_packer_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        full;
    logic        wreq;
    logic [7:0]  wd;
    logic        busy;
    logic [7:0]  frame_cnt;

    modport master (
        output in_valid, in_data, in_last, full,
        input  in_ready, wreq, wd, busy, frame_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, full,
        output in_ready, wreq, wd, busy, frame_cnt
    );
endinterface

// File: rtl/fifo_wr_packer.sv
// Serializes 32-bit words MSB-first into FIFO bytes, with an optional XOR checksum byte per frame (FIFO_WR_CSUM_EN).
// Latency: first byte on wd/wreq the cycle after acceptance; then 1 byte/cycle, frames separated by one idle cycle.
// Backpressure: full gates wreq combinationally and freezes all state; in_ready only opens on the last byte of a non-final word.
module fifo_wr_packer (
    input  logic            clkw,
    input  logic            rst,
    fifo_wr_packer_if.slave bus
);

`ifdef FIFO_WR_CSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CSUM = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  bidx_q;
    logic [31:0] word_q;
    logic        last_q;
    logic [7:0]  frame_cnt_q;
    logic [7:0]  byte_sel;
    logic        wr_en;
    logic        word_done;
    logic        accept;
    logic        frame_done;

`ifdef FIFO_WR_CSUM_EN
    logic [7:0]  csum_q;
`endif

    always_comb begin
        case (bidx_q)
            2'd0:    byte_sel = word_q[31:24];
            2'd1:    byte_sel = word_q[23:16];
            2'd2:    byte_sel = word_q[15:8];
            default: byte_sel = word_q[7:0];
        endcase
    end

    // full must kill the write request in the same cycle; the FIFO writes whenever wreq is high.
    assign wr_en     = (state_q != IDLE) & ~bus.full;
    assign word_done = (state_q == SHIFT) & (bidx_q == 2'd3) & wr_en;
    assign accept    = bus.in_valid & bus.in_ready;

`ifdef FIFO_WR_CSUM_EN
    assign frame_done = (state_q == CSUM) & wr_en;
`else
    assign frame_done = word_done & last_q;
`endif

    always_ff @(posedge clkw or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (word_done) begin
                    if (accept) begin
                        state_d = SHIFT;
`ifdef FIFO_WR_CSUM_EN
                    end else if (last_q) begin
                        state_d = CSUM;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef FIFO_WR_CSUM_EN
            CSUM: begin
                if (wr_en) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.wreq      = wr_en;
        bus.busy      = (state_q != IDLE);
        bus.in_ready  = (state_q == IDLE) | (word_done & ~last_q);
        bus.frame_cnt = frame_cnt_q;
        bus.wd        = 8'h00;
        case (state_q)
            SHIFT:   bus.wd = byte_sel;
`ifdef FIFO_WR_CSUM_EN
            CSUM:    bus.wd = csum_q;
`endif
            default: bus.wd = 8'h00;
        endcase
    end

    always_ff @(posedge clkw or negedge rst) begin
        if (!rst) begin
            word_q      <= 32'h0;
            last_q      <= 1'b0;
            bidx_q      <= 2'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            if (accept) begin
                word_q <= bus.in_data;
                last_q <= bus.in_last;
                bidx_q <= 2'd0;
            end else if (wr_en && (state_q == SHIFT)) begin
                bidx_q <= bidx_q + 2'd1;
            end
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

`ifdef FIFO_WR_CSUM_EN
    always_ff @(posedge clkw or negedge rst) begin
        if (!rst) begin
            csum_q <= 8'h00;
        end else if (wr_en && (state_q == CSUM)) begin
            csum_q <= 8'h00;
        end else if (wr_en && (state_q == SHIFT)) begin
            csum_q <= csum_q ^ byte_sel;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer: a byte-queue model predicts every FIFO write, plus literal checks per scenario.
module tb_fifo_wr_packer;
    logic clkw = 1'b0;
    logic rst;

    fifo_wr_packer_if bus();

    fifo_wr_packer dut (
        .clkw (clkw),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clkw = ~clkw;

`ifdef FIFO_WR_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    int         nvec = 0;
    int         nerr = 0;
    int         cyc  = 0;
    logic [7:0] expq[$];
    bit         eofq[$];
    logic [7:0] exp_cnt = 8'd0;
    logic [7:0] acc = 8'd0;
    logic [7:0] wlog[$];
    int         wcyc[$];
    logic [7:0] ev[9];
    logic [7:0] b;
    logic       e_ready, e_wreq, e_busy;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clkw) cyc <= cyc + 1;

    // Model: a frame is the MSB-first bytes of its words, plus the XOR of them when the checksum is enabled.
    always @(negedge clkw) begin
        if (!rst) begin
            expq.delete();
            eofq.delete();
            exp_cnt = 8'd0;
            acc     = 8'd0;
        end else begin
            e_busy  = (expq.size() != 0);
            e_wreq  = e_busy && !bus.full;
            e_ready = !e_busy || (expq.size() == 1 && e_wreq && !eofq[0]);
            chk("busy", bus.busy, e_busy);
            chk("wreq", bus.wreq, e_wreq);
            chk("in_ready", bus.in_ready, e_ready);
            chk("frame_cnt", bus.frame_cnt, exp_cnt);
            if (bus.wreq) begin
                wlog.push_back(bus.wd);
                wcyc.push_back(cyc);
            end
            if (e_wreq) begin
                chk("wd", bus.wd, expq[0]);
                if (eofq[0]) exp_cnt = exp_cnt + 8'd1;
                void'(expq.pop_front());
                void'(eofq.pop_front());
            end
            if (bus.in_valid && e_ready) begin
                for (int i = 3; i >= 0; i--) begin
                    b = bus.in_data[8*i +: 8];
                    expq.push_back(b);
                    acc = acc ^ b;
`ifdef FIFO_WR_CSUM_EN
                    eofq.push_back(1'b0);
`else
                    eofq.push_back(bus.in_last && (i == 0));
`endif
                end
                if (bus.in_last) begin
`ifdef FIFO_WR_CSUM_EN
                    expq.push_back(acc);
                    eofq.push_back(1'b1);
`endif
                    acc = 8'd0;
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l, input bit keep);
        bit got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clkw);
            got = bus.in_ready;
            @(posedge clkw);
            #1;
        end
        chk("accept", got, 1);
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clkw);
            done = !bus.busy && (expq.size() == 0);
        end
        chk("idle", done, 1);
        @(posedge clkw);
        #1;
    endtask

    task automatic check_log(input string name, input int n);
        chk({name, "_len"}, wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++) chk(name, wlog[i], ev[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        bus.in_last  = 1'b0;
        bus.full     = 1'b0;
        repeat (3) @(posedge clkw);
        #1;
        chk("rst_wreq", bus.wreq, 0);
        chk("rst_wd", bus.wd, 8'h00);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cnt", bus.frame_cnt, 0);
        rst = 1'b1;
        @(posedge clkw);
        #1;

        // Single word frame
        wlog.delete(); wcyc.delete();
        send_word(32'hA1B2C3D4, 1'b1, 1'b0);
        wait_idle();
        ev = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        check_log("single", 4 + CS);
        for (int i = 1; i < wcyc.size(); i++) chk("single_gap", wcyc[i] - wcyc[0], i);
        chk("single_cnt", bus.frame_cnt, 1);

        // Full stall while C3 is pending
        wlog.delete(); wcyc.delete();
        send_word(32'hA1B2C3D4, 1'b1, 1'b0);
        @(posedge clkw); #1;
        @(posedge clkw); #1;
        bus.full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkw);
            chk("stall_wreq", bus.wreq, 0);
            chk("stall_wd", bus.wd, 8'hC3);
            @(posedge clkw);
            #1;
        end
        bus.full = 1'b0;
        wait_idle();
        check_log("stall", 4 + CS);
        chk("stall_cnt", bus.frame_cnt, 2);

        // Back-to-back words in one frame
        wlog.delete(); wcyc.delete();
        send_word(32'h01020304, 1'b0, 1'b1);
        send_word(32'h05060708, 1'b1, 1'b0);
        wait_idle();
        ev = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        check_log("b2b", 8 + CS);
        for (int i = 1; i < wcyc.size(); i++) chk("b2b_gap", wcyc[i] - wcyc[0], i);
        chk("b2b_cnt", bus.frame_cnt, 3);

        // Frame counter wrap: 3 + 252 = 255, then 0
        for (int i = 0; i < 256; i++) begin
            send_word({i[7:0], 8'h11, 8'h22, 8'h33}, 1'b1, 1'b0);
            if (i == 251 || i == 252) begin
                wait_idle();
                chk("wrap_cnt", bus.frame_cnt, (i == 251) ? 32'd255 : 32'd0);
            end
        end
        wait_idle();
        chk("wrap_end", bus.frame_cnt, 3);

        // Asynchronous reset after B2 has been written
        wlog.delete(); wcyc.delete();
        send_word(32'hA1B2C3D4, 1'b1, 1'b0);
        @(posedge clkw); #1;
        @(posedge clkw); #2;
        rst = 1'b0;
        #1;
        chk("mid_wreq", bus.wreq, 0);
        chk("mid_wd", bus.wd, 8'h00);
        chk("mid_busy", bus.busy, 0);
        chk("mid_ready", bus.in_ready, 1);
        chk("mid_cnt", bus.frame_cnt, 0);
        repeat (2) @(posedge clkw);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clkw);
        #1;
        chk("mid_log_len", wlog.size(), 2);
        chk("mid_cnt_after", bus.frame_cnt, 0);
        wlog.delete(); wcyc.delete();
        send_word(32'h01020304, 1'b1, 1'b0);
        wait_idle();
        ev = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        check_log("post_rst", 4 + CS);
        chk("post_rst_cnt", bus.frame_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fifo_wr_packer.md
# fifo_wr_packer

Write-side feeder for the dual-clock byte FIFO, running entirely in the `clkw` domain. It accepts 32-bit words on a valid/ready handshake and serializes each word into four bytes, most significant byte first. It drives the FIFO's `WREQ`/`WD` pair, which are `wreq`/`wd` here, and throttles on the FIFO full flag `f`, which arrives here as `full`. Words are grouped into frames delimited by `in_last`; an optional XOR checksum byte closes each frame.

## Interface
Parameters: none.

Ports:
- `clkw` in 1: write-domain clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: upstream word valid.
- `in_data` in 32: upstream word.
- `in_last` in 1: word is the final word of its frame; sampled with `in_data`.
- `in_ready` out 1: block can accept a word this cycle.
- `full` in 1: FIFO full flag; used combinationally.
- `wreq` out 1: FIFO write request.
- `wd` out 8: FIFO write data.
- `busy` out 1: a word or checksum byte is held.
- `frame_cnt` out 8: number of completed frames, wrapping.

## Operation
- Word transfer occurs when `in_valid & in_ready`.
- State machine:
  - IDLE: nothing held.
  - SHIFT: word held; byte index `bidx` runs 0..3.
  - CSUM: checksum byte held; only exists with the macro.
- `wd` selects by `bidx`:
  - 0 → `in_data[31:24]`
  - 1 → `[23:16]`
  - 2 → `[15:8]`
  - 3 → `[7:0]`
  - In CSUM, `wd` is the checksum register.
- `wreq = (state != IDLE) & ~full`, combinational.
  - `wreq` is never high while `full` = 1. This is mandatory: the FIFO memory writes whenever its write request is high and would overwrite unread data.
- A byte is consumed on every edge where `wreq` = 1.
  - SHIFT: `bidx` increments.
  - At `bidx` = 3 the word is finished.
- `in_ready = (state == IDLE) | (state == SHIFT & bidx == 3 & wreq & ~last_q)`.
  - This allows back-to-back words within a frame with no bubble.
- When a word finishes:
  - If a new word is accepted in the same cycle: load it, `bidx` ← 0, stay in SHIFT.
  - Else, if `last_q` and the macro is enabled: go to CSUM.
  - Else: go to IDLE.
- When a frame completes (last byte of the `last` word without the macro, or the CSUM byte with it): `frame_cnt` increments, 255 → 0, and the state returns to IDLE.
  - `in_ready` stays low during the final byte of a frame, so a new frame always starts from IDLE.
- `busy = (state != IDLE)`.
- Reset mid-frame: the partial frame is discarded. No further bytes are emitted and the checksum is cleared.

## Timing
Reset values:
- state IDLE
- `bidx` 0
- `wreq` 0
- `wd` 0x00
- `in_ready` 1
- `busy` 0
- `frame_cnt` 0
- checksum 0x00

Latency and throughput:
- Latency: the first byte of an accepted word appears on `wd`, with `wreq` high, in the cycle after acceptance if `full` = 0.
- Throughput:
  - Sustained 1 byte/cycle within a frame.
  - Frames are separated by one IDLE cycle.
  - With the macro, a frame takes 4·N+1 bytes.

Handshake and stalls:
- Stall: while `full` = 1, `wreq` = 0 and `wd`, `bidx` and state hold. Emission resumes in the first cycle `full` = 0.
- `in_valid` may drop at any time. `in_data` and `in_last` are only sampled on transfer.
- `full` rising in the same cycle as a byte is pending: that byte is not written. The combinational gate removes `wreq` that cycle.

## Configuration
- `FIFO_WR_CSUM_EN` defined:
  - An 8-bit checksum register is active.
  - It is XOR-accumulated with every emitted byte of the frame.
  - It is emitted in state CSUM after the `last` word.
  - It is cleared to 0 when the CSUM byte is written and on reset.
- Not defined:
  - No CSUM state and no checksum register.
  - A frame ends with the last data byte.
  - `frame_cnt` increments on that byte.

## Test plan
- Reset: assert `rst`=0 asynchronously mid-word. Required: all outputs take their reset values immediately; after release the next word starts at byte 0 with `frame_cnt` = 0.
- Single word: `in_data`=0xA1B2C3D4, `in_last`=1, `full`=0. Required: `wd` = A1, B2, C3, D4 on 4 consecutive `wreq` cycles. With `FIFO_WR_CSUM_EN`, a fifth byte 0x04 follows. `frame_cnt` then reads 1.
- Full stall: same word, `full`=1 for 3 cycles while `wd`=C3. Required: `wreq`=0 for those 3 cycles and `wd` holds C3; C3 is written once `full`=0, then D4.
- Back-to-back: words 0x01020304 (last=0) and 0x05060708 (last=1) with `in_valid` held high. Required: bytes 01..08 on 8 consecutive cycles with no gap. Checksum 0x08 follows when enabled.
- Wrap: 256 single-word frames. Required: `frame_cnt` goes 255 → 0 and continues.
- Reset mid-frame: deassert `rst` after byte B2 of a frame. Required: no further bytes; `frame_cnt` unchanged from 0. The next frame's checksum excludes the discarded bytes.
